// File: rtl/rf_read_seq_pkg.sv
// Shared definitions for the register-file read sequencer.
// Contents: geometry of the 8x4 register file and the sequencer FSM state encoding.
package rf_read_seq_pkg;

  localparam int unsigned DATA_W = 4;  // bits per register
  localparam int unsigned DEPTH  = 8;  // number of registers
  localparam int unsigned ADDR_W = 3;  // log2(DEPTH)

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/rf_rdmux8.sv
// 8:1 read multiplexer for the register file, built as a three-level tree of 2:1 muxes.
// Ports:
//   i_reg_flat : flattened register contents, reg i on bits [DATA_W*i +: DATA_W]
//   i_sel      : register index to read
//   o_data     : selected register value (combinational)
module rf_rdmux8
  import rf_read_seq_pkg::*;
(
  input  logic [DEPTH*DATA_W-1:0] i_reg_flat,
  input  logic [ADDR_W-1:0]       i_sel,
  output logic [DATA_W-1:0]       o_data
);

  logic [DATA_W-1:0] w_lvl0 [8];
  logic [DATA_W-1:0] w_lvl1 [4];
  logic [DATA_W-1:0] w_lvl2 [2];

  for (genvar g = 0; g < 8; g++) begin : g_lvl0
    assign w_lvl0[g] = i_reg_flat[DATA_W*g +: DATA_W];
  end

  // Each level resolves one select bit, LSB first.
  for (genvar g = 0; g < 4; g++) begin : g_lvl1
    assign w_lvl1[g] = i_sel[0] ? w_lvl0[2*g+1] : w_lvl0[2*g];
  end

  for (genvar g = 0; g < 2; g++) begin : g_lvl2
    assign w_lvl2[g] = i_sel[1] ? w_lvl1[2*g+1] : w_lvl1[2*g];
  end

  assign o_data = i_sel[2] ? w_lvl2[1] : w_lvl2[0];

endmodule

// File: rtl/rf_read_seq.sv
// Read-side sequencer for the 8x4 register file. Accepts single reads and wrapping bursts
// over a valid/ready request channel and returns one registered beat at a time.
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_reg_flat      : register contents, reg i on bits [DATA_W*i +: DATA_W]
//   i_req_valid/o_req_ready, i_req_addr, i_req_len : request (len = beats - 1)
//   o_rsp_valid/i_rsp_ready, o_rsp_data, o_rsp_addr, o_rsp_last : response beat
//   o_busy          : a burst is in progress or a beat is still held
module rf_read_seq
  import rf_read_seq_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [DEPTH*DATA_W-1:0] i_reg_flat,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [ADDR_W-1:0]       i_req_addr,
  input  logic [ADDR_W-1:0]       i_req_len,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_W-1:0]       o_rsp_data,
  output logic [ADDR_W-1:0]       o_rsp_addr,
  output logic                    o_rsp_last,
  output logic                    o_busy
);

  state_e              r_state;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic [ADDR_W-1:0]   r_rsp_addr;
  logic                r_rsp_last;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [ADDR_W-1:0]   r_count;

  logic                w_slot_free;
  logic                w_req_fire;
  logic [ADDR_W-1:0]   w_sel;
  logic [DATA_W-1:0]   w_rd_data;

  // The single output slot can take a new beat when empty or being drained this cycle.
  assign w_slot_free = !r_rsp_valid || i_rsp_ready;
  assign o_req_ready = (r_state == IDLE) && w_slot_free;
  assign w_req_fire  = i_req_valid && o_req_ready;

  // In IDLE the mux looks at the incoming request so the first beat loads on the accept edge.
  assign w_sel = (r_state == IDLE) ? i_req_addr : r_cur_addr;

  rf_rdmux8 u_rdmux (
    .i_reg_flat (i_reg_flat),
    .i_sel      (w_sel),
    .o_data     (w_rd_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_addr  <= '0;
      r_rsp_last  <= 1'b0;
      r_cur_addr  <= '0;
      r_count     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req_fire) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rd_data;
            r_rsp_addr  <= i_req_addr;
            r_rsp_last  <= (i_req_len == '0);
            r_cur_addr  <= i_req_addr + ADDR_W'(1);
            r_count     <= i_req_len;
            r_state     <= (i_req_len != '0) ? BURST : IDLE;
          end else if (w_slot_free) begin
            r_rsp_valid <= 1'b0;
          end
        end
        BURST: begin
          if (w_slot_free) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rd_data;
            r_rsp_addr  <= r_cur_addr;
            r_rsp_last  <= (r_count == ADDR_W'(1));
            r_cur_addr  <= r_cur_addr + ADDR_W'(1);
            r_count     <= r_count - ADDR_W'(1);
            // count==1 means this load is the final beat.
            if (r_count == ADDR_W'(1)) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_addr  = r_rsp_addr;
  assign o_rsp_last  = r_rsp_last;
  assign o_busy      = (r_state == BURST) || r_rsp_valid;

endmodule

// File: tb/tb_rf_read_seq.sv
// Self-checking bench for rf_read_seq: directed scenarios plus randomized bursts,
// checked against a beat-list reference model of the read rules.
module tb_rf_read_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] reg_flat;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_addr;
  logic [2:0]  req_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_data;
  logic [2:0]  rsp_addr;
  logic        rsp_last;
  logic        busy;

  // Register-file write port model: writes land on the clock edge.
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [3:0]  wr_data;
  logic [3:0]  regs [8];

  typedef struct packed {
    logic [2:0] addr;
    logic [3:0] data;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int    checks;
  int    errors;

  rf_read_seq dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_reg_flat  (reg_flat),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_addr  (req_addr),
    .i_req_len   (req_len),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_addr  (rsp_addr),
    .o_rsp_last  (rsp_last),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (wr_en) regs[wr_addr] <= wr_data;
  end

  always_comb begin
    reg_flat = '0;
    for (int i = 0; i < 8; i++) reg_flat[4*i +: 4] = regs[i];
  end

  // All tasks start and end in the drive phase (just after a rising edge).
  task automatic write_reg(input logic [2:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Expected beats of a request, from the register contents seen at the accept edge.
  task automatic push_beats(input logic [2:0] a, input logic [2:0] l);
    beat_t b;
    for (int k = 0; k <= int'(l); k++) begin
      b.addr = a + 3'(k);
      b.data = regs[b.addr];
      b.last = (k == int'(l));
      exp_q.push_back(b);
    end
  endtask

  task automatic issue(input logic [2:0] a, input logic [2:0] l);
    bit ok;
    ok = 0;
    req_valid = 1'b1; req_addr = a; req_len = l;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready) begin
        push_beats(a, l);
        ok = 1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL issue_accept: accepted %0d want 1 (addr %0d len %0d)", ok, a, l);
    end
  endtask

  // Consume beats with a per-cycle stall mask, comparing every cycle against the model.
  task automatic drain(input logic [31:0] stall, input string name);
    bit    done;
    logic  exp_rdy;
    done = 0;
    for (int c = 0; c < 64; c++) begin
      rsp_ready = (c < 32) ? !stall[c] : 1'b1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL %s valid c%0d: got %b want %b", name, c, rsp_valid, exp_q.size() != 0);
      end
      checks++;
      if (busy !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL %s busy c%0d: got %b want %b", name, c, busy, exp_q.size() != 0);
      end
      // A new request is only takeable once the last beat is loaded and the slot can drain.
      exp_rdy = (exp_q.size() == 0) || ((exp_q.size() == 1) && rsp_ready);
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL %s req_ready c%0d: got %b want %b", name, c, req_ready, exp_rdy);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if ({rsp_addr, rsp_data, rsp_last} !== exp_q[0]) begin
          errors++;
          $display("FAIL %s beat c%0d: got a%0d d%h l%b want a%0d d%h l%b", name, c,
                   rsp_addr, rsp_data, rsp_last, exp_q[0].addr, exp_q[0].data, exp_q[0].last);
        end
        if (rsp_ready) void'(exp_q.pop_front());
      end else begin
        done = 1;
      end
      @(posedge clk); #1;
      if (done) break;
    end
    rsp_ready = 1'b1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s drain_timeout: got %0d want 1", name, done);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; rsp_ready = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #12;
    checks++;
    if ({rsp_valid, rsp_data, rsp_addr, rsp_last} !== 9'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {rsp_valid, rsp_data, rsp_addr, rsp_last});
    end
    checks++;
    if ({req_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_ready_busy: got %b want 10", {req_ready, busy});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    for (int i = 0; i < 8; i++) write_reg(3'(i), (i == 3) ? 4'hA : 4'(i + 2));
    rsp_ready = 1'b1;
    issue(3'd3, 3'd0);
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data, rsp_addr, rsp_last} !== {1'b1, 4'hA, 3'd3, 1'b1}) begin
      errors++;
      $display("FAIL single_beat: got v%b d%h a%0d l%b want v1 dA a3 l1",
               rsp_valid, rsp_data, rsp_addr, rsp_last);
    end
    exp_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL single_after: got v%b busy%b rdy%b want v0 busy0 rdy1",
               rsp_valid, busy, req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap_burst();
    for (int i = 0; i < 8; i++) write_reg(3'(i), 4'(i + 1));
    issue(3'd6, 3'd3);
    drain(32'h0, "wrap_burst");
  endtask

  task automatic test_backpressure();
    issue(3'd6, 3'd3);
    // Beat 2 is presented from cycle 1; hold it for three cycles.
    drain(32'h0000_000E, "backpressure");
  endtask

  task automatic test_read_during_write();
    write_reg(3'd2, 4'h5);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 3'd2; req_len = 3'd0;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'hC;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rdw_ready: got %b want 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data} !== {1'b1, 4'h5}) begin
      errors++;
      $display("FAIL rdw_old_value: got v%b d%h want v1 d5", rsp_valid, rsp_data);
    end
    @(posedge clk); #1;
    issue(3'd2, 3'd0);
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data} !== {1'b1, 4'hC}) begin
      errors++;
      $display("FAIL rdw_new_value: got v%b d%h want v1 dC", rsp_valid, rsp_data);
    end
    exp_q.delete();
    @(posedge clk); #1;
    drain(32'h0, "rdw_tail");
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    issue(3'd4, 3'd1);
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_addr, rsp_last} !== {1'b1, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL b2b_first: got v%b a%0d l%b want v1 a4 l0", rsp_valid, rsp_addr, rsp_last);
    end
    void'(exp_q.pop_front());
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 3'd0; req_len = 3'd0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_addr, rsp_last, req_ready} !== {1'b1, 3'd5, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_last_ready: got v%b a%0d l%b rdy%b want v1 a5 l1 rdy1",
               rsp_valid, rsp_addr, rsp_last, req_ready);
    end
    void'(exp_q.pop_front());
    push_beats(3'd0, 3'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain(32'h0, "b2b_second");
  endtask

  task automatic test_reset_mid_burst();
    rsp_ready = 1'b1;
    issue(3'd1, 3'd7);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_addr} !== {1'b1, 3'd2}) begin
      errors++;
      $display("FAIL midrst_beat2: got v%b a%0d want v1 a2", rsp_valid, rsp_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, req_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL midrst_async: got v%b rdy%b busy%b want v0 rdy1 busy0",
               rsp_valid, req_ready, busy);
    end
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    issue(3'd5, 3'd0);
    drain(32'h0, "midrst_after");
  endtask

  task automatic test_random();
    logic [2:0]  a;
    logic [2:0]  l;
    logic [31:0] stall;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) write_reg(3'($urandom_range(0, 7)), 4'($urandom));
      a     = 3'($urandom_range(0, 7));
      l     = 3'($urandom_range(0, 7));
      stall = $urandom & $urandom;
      rsp_ready = 1'b1;
      issue(a, l);
      drain(stall, "random");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_read();
    test_wrap_burst();
    test_backpressure();
    test_read_during_write();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_read_seq.md
Name: rf_read_seq

Overview:
Read-side sequencer for the 8x4 gate-level register file, which has only a write path today. It accepts read requests over a valid/ready handshake, supports single reads and wrapping bursts, and returns registered 4-bit data with address and last-beat tags. It sits beside the register file and reads its eight 4-bit register outputs through a flattened bus.

Parameters:
- DATA_W, 4, bits per register
- DEPTH, 8, number of registers (power of two)
- ADDR_W, 3, log2(DEPTH)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- reg_flat  in  DEPTH*DATA_W  register contents; reg i on bits [DATA_W*i+DATA_W-1 : DATA_W*i]
- req_valid  in  1  read request valid
- req_ready  out  1  request accepted when req_valid and req_ready are both high
- req_addr  in  ADDR_W  start address
- req_len  in  ADDR_W  beats minus 1 (0 to 7)
- rsp_valid  out  1  response beat valid
- rsp_ready  in  1  consumer ready
- rsp_data  out  DATA_W  read data
- rsp_addr  out  ADDR_W  address of this beat
- rsp_last  out  1  final beat of the request
- busy  out  1  state is BURST or rsp_valid is high

Behaviour:
- Reset (asynchronous, rst_n low):
  - state goes to IDLE.
  - rsp_valid, rsp_data, rsp_addr, rsp_last, cur_addr and count all clear to 0.
  - req_ready = 1 and busy = 0.
  - Reset asserted mid-burst abandons the burst; no partial beat remains visible.
- Output slot:
  - One output register holds one beat.
  - slot_free = !rsp_valid || rsp_ready.
  - Once rsp_valid is high, rsp_data, rsp_addr and rsp_last stay stable until consumed.
- req_ready = (state==IDLE) && slot_free. This is combinational.
- FSM, IDLE state:
  - On request handshake, load the first beat at that edge:
    - rsp_data <= reg_flat[req_addr]
    - rsp_addr <= req_addr
    - rsp_last <= (req_len==0)
    - rsp_valid <= 1
  - Also set cur_addr <= req_addr+1 (mod DEPTH) and count <= req_len.
  - If req_len != 0, go to BURST; otherwise stay in IDLE.
  - Latency: first beat is visible the cycle after the handshake.
- FSM, BURST state:
  - On each edge with slot_free, load the beat for cur_addr:
    - rsp_data <= reg_flat[cur_addr]
    - rsp_addr <= cur_addr
    - rsp_last <= (count==1)
  - Then increment cur_addr (wrap 7 to 0) and decrement count.
  - When a beat with last set is loaded, go to IDLE.
  - Throughput is one beat per cycle while rsp_ready is held high.
- IDLE with no new request: when the held beat is consumed, rsp_valid <= 0.
- Back-to-back requests: a new request can be accepted on the same edge that the last beat is consumed. There is no bubble.
- Read-during-write: data is sampled from reg_flat at the load edge. A write to the same register on that edge is not seen, so the pre-write value is returned. Later beats see updated contents (no snapshot).
- Address arithmetic is modulo DEPTH. req_len is unsigned, giving 1 to 8 beats.
- req_addr and req_len are don't-care when req_valid is low.

Decomposition:
- Shared package / header:
  - DATA_W, DEPTH, ADDR_W
  - state encodings IDLE=1'b0, BURST=1'b1
- Natural sub-module: rf_rdmux8, an 8:1 x DATA_W read mux built as a tree of 2:1 muxes.
  - Inputs: reg_flat and select.
  - It is instantiated once, with select = (state==IDLE) ? req_addr : cur_addr.
- The output register and FSM stay in the top module.

Test Plan:
1. Single read, no backpressure:
   - Stimulus: reg3=4'hA, req addr=3 len=0, rsp_ready=1.
   - Required: next cycle rsp_valid=1, rsp_data=A, rsp_addr=3, rsp_last=1; the cycle after, rsp_valid=0 and busy=0.
2. Wrapping burst:
   - Stimulus: reg i = i+1, req addr=6 len=3, rsp_ready=1.
   - Required: four consecutive beats with data 7,8,1,2 at addresses 6,7,0,1; rsp_last only on the 4th; req_ready=0 during the burst.
3. Backpressure:
   - Stimulus: same burst as scenario 2, with rsp_ready low for 3 cycles while beat 2 is presented.
   - Required: data=8 and addr=7 held stable for all 3 cycles; sequence continues 1,2 with no beat lost or duplicated.
4. Read-during-write:
   - Stimulus: reg2 changes from 5 to C on the request-accept edge for addr=2 len=0.
   - Required: rsp_data=5. A repeat request then returns C.
5. Back-to-back requests:
   - Stimulus: 2nd request (addr=0 len=0) held valid while the last beat of a 2-beat burst is consumed.
   - Required: req_ready=1 in that cycle; new beat valid on the very next cycle; rsp_valid never drops.
6. Reset mid-burst:
   - Stimulus: rst_n low after beat 2 of an 8-beat burst.
   - Required: rsp_valid=0 and req_ready=1 immediately (asynchronous); after release, a new req addr=5 len=0 returns reg5 correctly.
